// File: rtl/conv_output_packer_if.sv
// conv_output_packer_if
//   AXI4-Stream style beat channel carrying packed convolution output.
//   Ports (signals):
//     tvalid  beat present           (master -> slave)
//     tready  sink can accept        (slave  -> master)
//     tdata   OUT_W-bit packed beat  (master -> slave)
//     tkeep   OUT_W/8 byte enables   (master -> slave)
//     tlast   final beat of a run    (master -> slave)
interface conv_output_packer_if #(
   parameter int OUT_W = 128
);
   logic               tvalid;
   logic               tready;
   logic [OUT_W-1:0]   tdata;
   logic [OUT_W/8-1:0] tkeep;
   logic               tlast;

   modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/conv_output_packer.sv
// conv_output_packer
//   Packs RATIO = OUT_W/IN_W unthrottled input words into each output beat,
//   buffers beats in a DEPTH-entry FIFO (output register included) and drives
//   an AXI4-Stream master. tlast and a partial tkeep come from the word count
//   latched on start; in_stall asks upstream to pause before the FIFO fills.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     cfg_total_words    words in the run, latched on start
//     start              one-cycle pulse arming a run
//     in_data/in_valid   input word (no ready)
//     in_stall           registered pause request
//     m_axis             packed beat stream (master modport)
//     busy, done         run in progress / end-of-run pulse
//     overflow           sticky: a beat was dropped on a full FIFO
//     unexpected         sticky: in_valid seen outside RUN
//     level              beats held (memory + output register)
module conv_output_packer #(
   parameter int IN_W         = 64,
   parameter int OUT_W        = 128,
   parameter int DEPTH        = 512,
   parameter int STALL_MARGIN = 16,
   parameter int CNT_W        = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CNT_W-1:0]           cfg_total_words,
   input  logic                       start,
   input  logic [IN_W-1:0]            in_data,
   input  logic                       in_valid,
   output logic                       in_stall,
   conv_output_packer_if.master       m_axis,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic                       unexpected,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int RATIO      = OUT_W / IN_W;
   localparam int LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int KEEP_W     = OUT_W / 8;
   localparam int LANE_BYTES = IN_W / 8;
   localparam int AW         = $clog2(DEPTH);
   localparam int LVL_W      = $clog2(DEPTH + 1);
   localparam int ENT_W      = OUT_W + KEEP_W + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   total_q, count_q, count_inc;
   logic [OUT_W-1:0]   pack_data_q, pack_data_n;
   logic [RATIO-1:0]   pack_lanes_q, pack_lanes_n;
   logic [LANE_W-1:0]  lane;
   logic               word_fire, is_last_word, run_start, zero_start;
   logic               push_req, push_ok, pop, drain_exit;
   logic [KEEP_W-1:0]  push_keep;
   logic [ENT_W-1:0]   push_entry;
   logic [ENT_W-1:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_next;
   logic               mem_has, out_load, load_from_mem, bypass, mem_write;
   logic               out_valid_q, out_last_q;
   logic [OUT_W-1:0]   out_data_q;
   logic [KEEP_W-1:0]  out_keep_q;
   logic               in_stall_q, done_q, overflow_q, unexpected_q, last_dropped_q;

   // ---------------- packer ----------------
   assign run_start    = (state_q == S_IDLE) && start && (cfg_total_words != '0);
   assign zero_start   = (state_q == S_IDLE) && start && (cfg_total_words == '0);
   assign word_fire    = (state_q == S_RUN) && in_valid;
   assign count_inc    = count_q + CNT_W'(1);
   assign is_last_word = (count_inc == total_q);
   assign lane         = (RATIO > 1) ? count_q[LANE_W-1:0] : '0;
   assign push_req     = word_fire && ((lane == LAST_LANE) || is_last_word);

   always_comb begin
      pack_data_n  = pack_data_q;
      pack_lanes_n = pack_lanes_q;
      push_keep    = '0;
      if (word_fire) begin
         for (int unsigned k = 0; k < RATIO; k++) begin
            if (lane == LANE_W'(k)) begin
               pack_data_n[k*IN_W +: IN_W] = in_data;
               pack_lanes_n[k]             = 1'b1;
            end
         end
      end
      for (int unsigned k = 0; k < RATIO; k++) begin
         push_keep[k*LANE_BYTES +: LANE_BYTES] = {LANE_BYTES{pack_lanes_n[k]}};
      end
   end

   assign push_entry = {is_last_word, push_keep, pack_data_n};

   // ---------------- FIFO with registered fall-through output ----------------
   // The memory holds at most DEPTH-1 beats; the remaining slot is the output
   // register, so level counts both.
   assign pop           = out_valid_q && m_axis.tready;
   assign push_ok       = push_req && ((level_q < LVL_W'(DEPTH)) || pop);
   assign mem_has       = level_q > LVL_W'(out_valid_q);
   assign out_load      = !out_valid_q || pop;
   assign load_from_mem = out_load && mem_has;
   // An empty memory lets the beat go straight to the output register.
   assign bypass        = out_load && !mem_has && push_ok;
   assign mem_write     = push_ok && !bypass;
   assign level_next    = level_q + LVL_W'(push_ok) - LVL_W'(pop);

   always_ff @(posedge clk) begin
      if (mem_write) begin
         mem[wr_ptr_q] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         in_stall_q  <= 1'b0;
      end else begin
         level_q    <= level_next;
         in_stall_q <= level_next >= LVL_W'(DEPTH - STALL_MARGIN);
         if (mem_write) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (load_from_mem) begin
            {out_last_q, out_keep_q, out_data_q} <= mem[rd_ptr_q];
            rd_ptr_q    <= rd_ptr_q + AW'(1);
            out_valid_q <= 1'b1;
         end else if (bypass) begin
            {out_last_q, out_keep_q, out_data_q} <= push_entry;
            out_valid_q <= 1'b1;
         end else if (out_load) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // ---------------- run datapath and status ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         total_q        <= '0;
         count_q        <= '0;
         pack_data_q    <= '0;
         pack_lanes_q   <= '0;
         done_q         <= 1'b0;
         overflow_q     <= 1'b0;
         unexpected_q   <= 1'b0;
         last_dropped_q <= 1'b0;
      end else begin
         done_q <= zero_start || ((state_q == S_DRAIN) && drain_exit);
         if (run_start) begin
            total_q      <= cfg_total_words;
            count_q      <= '0;
            pack_data_q  <= '0;
            pack_lanes_q <= '0;
         end else if (word_fire) begin
            count_q <= count_inc;
            if (push_req) begin
               pack_data_q  <= '0;
               pack_lanes_q <= '0;
            end else begin
               pack_data_q  <= pack_data_n;
               pack_lanes_q <= pack_lanes_n;
            end
         end
         overflow_q   <= (overflow_q && !run_start) || (push_req && !push_ok);
         unexpected_q <= (unexpected_q && !run_start) || (in_valid && (state_q != S_RUN));
         if (run_start) begin
            last_dropped_q <= 1'b0;
         end else if (push_req && is_last_word && !push_ok) begin
            last_dropped_q <= 1'b1;
         end
      end
   end

   // A dropped tlast beat can never handshake; finish once the FIFO empties.
   assign drain_exit = (pop && out_last_q) || (last_dropped_q && (level_q == '0));

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (run_start) state_n = S_RUN;
         S_RUN:   if (word_fire && is_last_word) state_n = S_DRAIN;
         S_DRAIN: if (drain_exit) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
   end

   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_data_q;
   assign m_axis.tkeep  = out_keep_q;
   assign m_axis.tlast  = out_last_q;
   assign in_stall      = in_stall_q;
   assign done          = done_q;
   assign overflow      = overflow_q;
   assign unexpected    = unexpected_q;
   assign level         = level_q;
endmodule

// File: tb/tb_conv_output_packer.sv
// tb_conv_output_packer
//   Directed bench for conv_output_packer (RATIO=2, DEPTH=16, STALL_MARGIN=4).
//   A behavioural model predicts packed beats into a queue as words are
//   driven; every cycle the DUT outputs are compared against the model.
module tb_conv_output_packer;
   localparam int IN_W   = 64;
   localparam int OUT_W  = 128;
   localparam int KEEP_W = OUT_W / 8;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;
   localparam int CNT_W  = 32;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   typedef struct packed {
      logic [OUT_W-1:0]  data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [CNT_W-1:0] cfg_total_words;
   logic             start;
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_stall;
   logic             busy, done, overflow, unexpected;
   logic [4:0]       level;

   conv_output_packer_if #(.OUT_W(OUT_W)) axis_if ();

   conv_output_packer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .STALL_MARGIN(MARGIN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .cfg_total_words(cfg_total_words), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_stall(in_stall),
      .m_axis(axis_if), .busy(busy), .done(done), .overflow(overflow),
      .unexpected(unexpected), .level(level)
   );

   always #5 clk = ~clk;

   int total_chk = 0;
   int bad_chk   = 0;

   beat_t            q[$];
   int               m_state = M_IDLE;
   int               m_count = 0;
   int               m_total = 0;
   logic [OUT_W-1:0] m_buf   = '0;
   logic [1:0]       m_lanes = '0;
   logic             m_ovf   = 1'b0;
   logic             m_unexp = 1'b0;
   logic             m_stall = 1'b0;
   logic             m_done  = 1'b0;

   task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      total_chk++;
      assert (obs === exp) else begin
         bad_chk++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare current outputs with the model, advance the model over the
   // coming clock edge using the inputs already driven, then clock.
   task automatic step();
      logic  pop, push, nd;
      int    st0, lane;
      beat_t b;
      chk("tvalid",     128'(axis_if.tvalid), 128'(q.size() > 0));
      chk("level",      128'(level),          128'(q.size()));
      chk("in_stall",   128'(in_stall),       128'(m_stall));
      chk("busy",       128'(busy),           128'(m_state != M_IDLE));
      chk("done",       128'(done),           128'(m_done));
      chk("overflow",   128'(overflow),       128'(m_ovf));
      chk("unexpected", 128'(unexpected),     128'(m_unexp));
      if (q.size() > 0) begin
         chk("tdata", axis_if.tdata,        q[0].data);
         chk("tkeep", 128'(axis_if.tkeep), 128'(q[0].keep));
         chk("tlast", 128'(axis_if.tlast), 128'(q[0].last));
      end
      if (rst) begin
         q.delete();
         m_state = M_IDLE; m_count = 0; m_total = 0; m_buf = '0; m_lanes = '0;
         m_ovf = 0; m_unexp = 0; m_stall = 0; m_done = 0;
      end else begin
         pop  = (q.size() > 0) && axis_if.tready;
         push = 0;
         nd   = 0;
         b    = '0;
         st0  = m_state;
         case (m_state)
            M_IDLE: if (start) begin
               if (cfg_total_words == 0) nd = 1;
               else begin
                  m_total = int'(cfg_total_words); m_count = 0; m_ovf = 0; m_unexp = 0;
                  m_buf = '0; m_lanes = '0; m_state = M_RUN;
               end
            end
            M_RUN: if (in_valid) begin
               lane = m_count % 2;
               m_buf[lane*IN_W +: IN_W] = in_data;
               m_lanes[lane] = 1'b1;
               m_count++;
               if (lane == 1 || m_count == m_total) begin
                  b.data = m_buf;
                  for (int k = 0; k < 2; k++) b.keep[k*8 +: 8] = m_lanes[k] ? 8'hFF : 8'h00;
                  b.last = (m_count == m_total);
                  push = 1;
                  m_buf = '0; m_lanes = '0;
                  if (b.last) m_state = M_DRAIN;
               end
            end
            M_DRAIN: if (pop && q[0].last) begin
               nd = 1; m_state = M_IDLE;
            end
            default: ;
         endcase
         if (st0 != M_RUN && in_valid) m_unexp = 1;
         if (push && !(q.size() < DEPTH || pop)) begin
            m_ovf = 1; push = 0;
         end
         if (pop) void'(q.pop_front());
         if (push) q.push_back(b);
         m_stall = (DEPTH - q.size()) <= MARGIN;
         m_done  = nd;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic word(input logic [IN_W-1:0] d);
      in_valid = 1'b1; in_data = d;
      step();
      in_valid = 1'b0; in_data = '0;
   endtask

   task automatic run_start(input int t);
      start = 1'b1; cfg_total_words = CNT_W'(t);
      step();
      start = 1'b0; cfg_total_words = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (!(m_state == M_IDLE && q.size() == 0 && !m_done) && n < maxc) begin
         step(); n++;
      end
      chk("drain_bound", 128'(n < maxc), 128'(1));
   endtask

   task automatic flush(input int maxc);
      int n = 0;
      while (q.size() > 0 && n < maxc) begin
         step(); n++;
      end
      chk("flush_bound", 128'(n < maxc), 128'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; cfg_total_words = '0; in_data = '0; in_valid = 1'b0;
      axis_if.tready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_tdata", axis_if.tdata, '0);
      chk("reset_tkeep", 128'(axis_if.tkeep), '0);
      idle(2);

      // six full words, full beats, tlast on the third
      axis_if.tready = 1'b1;
      run_start(6);
      for (int i = 1; i <= 6; i++) word(IN_W'(i));
      drain(20);

      // odd total: partial final beat
      run_start(5);
      for (int i = 1; i <= 5; i++) word(IN_W'(i));
      drain(20);

      // zero-length run
      run_start(0);
      idle(4);

      // backpressure: stall, saturation at DEPTH, dropped 17th beat
      axis_if.tready = 1'b0;
      run_start(36);
      for (int i = 1; i <= 34; i++) word(IN_W'(i));
      idle(3);
      axis_if.tready = 1'b1;
      flush(40);
      word(IN_W'(35));
      word(IN_W'(36));
      drain(20);

      // full FIFO with simultaneous pop and push
      axis_if.tready = 1'b0;
      run_start(36);
      for (int i = 1; i <= 33; i++) word(IN_W'(100 + i));
      axis_if.tready = 1'b1;
      for (int i = 34; i <= 36; i++) word(IN_W'(100 + i));
      drain(40);

      // stray word in IDLE, then reset mid-run with three beats queued
      word(IN_W'(77));
      idle(1);
      axis_if.tready = 1'b0;
      run_start(20);
      for (int i = 1; i <= 6; i++) word(IN_W'(200 + i));
      idle(1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(2);
      axis_if.tready = 1'b1;
      run_start(2);
      word(IN_W'(1));
      word(IN_W'(2));
      drain(20);
      idle(3);

      $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
      $finish;
   end
endmodule
